// File: rtl/pt_mem_pkg.sv
// Shared definitions for the page-table memory responder.
// Contents: FSM state encodings, Sv32 PTE bit positions shared with the
// PTW/TLB, and the byte-address decode helper returning {err, index}.
package pt_mem_pkg;

    // Responder FSM encodings
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWait  = 2'd1;
    localparam logic [1:0] StResp  = 2'd2;
    localparam logic [1:0] StClear = 2'd3;

    // Sv32 PTE bit positions
    localparam int unsigned PteV      = 0;
    localparam int unsigned PteR      = 1;
    localparam int unsigned PteW      = 2;
    localparam int unsigned PteX      = 3;
    localparam int unsigned PteU      = 4;
    localparam int unsigned PteG      = 5;
    localparam int unsigned PteA      = 6;
    localparam int unsigned PteD      = 7;
    localparam int unsigned PtePpnLsb = 10;

    typedef struct packed {
        logic        err;
        logic [29:0] index;
    } pt_dec_t;

    // Offset uses 32-bit modular arithmetic, so addr < base wraps to a huge
    // offset and lands in the out-of-range error case.
    function automatic pt_dec_t pt_addr_decode(input logic [31:0] addr,
                                               input logic [31:0] base,
                                               input int unsigned depth_log2);
        pt_dec_t     dec;
        logic [31:0] off;
        off       = addr - base;
        dec.err   = (addr[1:0] != 2'b00) || ((off >> (depth_log2 + 2)) != 32'd0);
        dec.index = off[31:2];
        return dec;
    endfunction

endpackage

// File: rtl/pt_req_fifo.sv
// Request FIFO for the page-table responder.
// Ports: clk/rst_n (async active-low), push_i/push_data_i write side,
// pop_i read side (only asserted when not empty), head_o current head entry,
// full_o/empty_o status. QDEPTH must be a power of two, at least 2.
module pt_req_fifo #(
    parameter int unsigned QDEPTH = 2,
    parameter int unsigned WIDTH  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(QDEPTH);

    logic [WIDTH-1:0] mem_q [QDEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;

    // Pointers wrap naturally because QDEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (PtrW+1)'(1);
                2'b01:   count_q <= count_q - (PtrW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (PtrW+1)'(QDEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/pt_mem_responder.sv
// Page-table memory responder for the PTW memory interface.
// Accepts single-beat PTE reads (mem_req_valid/mem_req_addr, no ready) into a
// QDEPTH-entry FIFO and answers each with a one-cycle mem_resp_valid pulse
// carrying mem_resp_data/mem_resp_err after LATENCY service cycles.
// cfg_wr_* loads the page table. busy reports pending work; req_drop pulses
// when a request is lost to a full FIFO.
// Build option: define PT_MEM_CLEAR_EN to zero the array after reset.
module pt_mem_responder
    import pt_mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned QDEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req_valid,
    input  logic [31:0] mem_req_addr,
    output logic        mem_resp_valid,
    output logic [31:0] mem_resp_data,
    output logic        mem_resp_err,
    input  logic        cfg_wr_en,
    input  logic [31:0] cfg_wr_addr,
    input  logic [31:0] cfg_wr_data,
    output logic        busy,
    output logic        req_drop
);

    localparam int unsigned Words  = 2 ** DEPTH_LOG2;
    localparam logic [3:0]  LatCnt = LATENCY[3:0];

    logic [31:0] mem_q [Words];

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] svc_addr_q, svc_addr_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic        resp_err_q, resp_err_d;

    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [31:0] fifo_head;

    pt_dec_t               svc_dec, cfg_dec;
    logic [DEPTH_LOG2-1:0] svc_idx;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] mem_widx;
    logic [31:0]           mem_wdata;
    logic                  unused_idx_bits;

    // A full FIFO still accepts a push when the FSM pops in the same cycle
    assign fifo_push = mem_req_valid && (!fifo_full || fifo_pop);
    assign req_drop  = mem_req_valid && fifo_full && !fifo_pop;

    pt_req_fifo #(
        .QDEPTH (QDEPTH),
        .WIDTH  (32)
    ) u_req_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (mem_req_addr),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign svc_dec         = pt_addr_decode(svc_addr_q, BASE_ADDR, DEPTH_LOG2);
    assign cfg_dec         = pt_addr_decode(cfg_wr_addr, BASE_ADDR, DEPTH_LOG2);
    assign svc_idx         = svc_dec.index[DEPTH_LOG2-1:0];
    // Upper index bits only matter through the err flag
    assign unused_idx_bits = ^{svc_dec.index[29:DEPTH_LOG2], cfg_dec.index[29:DEPTH_LOG2]};

`ifdef PT_MEM_CLEAR_EN
    logic [DEPTH_LOG2-1:0] clr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_q <= '0;
        end else if (state_q == StClear) begin
            clr_q <= clr_q + DEPTH_LOG2'(1);
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        svc_addr_d  = svc_addr_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        fifo_pop    = 1'b0;
        case (state_q)
            StIdle, StResp: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    svc_addr_d = fifo_head;
                    cnt_d      = LatCnt;
                    state_d    = StWait;
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    // Array read sees the pre-edge value, so a same-cycle cfg
                    // write to this word is not returned.
                    resp_err_d  = svc_dec.err;
                    resp_data_d = svc_dec.err ? 32'd0 : mem_q[svc_idx];
                    state_d     = StResp;
                end
            end
`ifdef PT_MEM_CLEAR_EN
            StClear: begin
                if (&clr_q) state_d = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef PT_MEM_CLEAR_EN
            state_q <= StClear;
`else
            state_q <= StIdle;
`endif
            cnt_q       <= '0;
            svc_addr_q  <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            svc_addr_q  <= svc_addr_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    always_comb begin
        mem_we    = cfg_wr_en && !cfg_dec.err;
        mem_widx  = cfg_dec.index[DEPTH_LOG2-1:0];
        mem_wdata = cfg_wr_data;
`ifdef PT_MEM_CLEAR_EN
        // Clear owns the write port; cfg writes are dropped meanwhile
        if (state_q == StClear) begin
            mem_we    = 1'b1;
            mem_widx  = clr_q;
            mem_wdata = 32'd0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_widx] <= mem_wdata;
    end

    assign mem_resp_valid = (state_q == StResp);
    assign mem_resp_data  = mem_resp_valid ? resp_data_q : 32'd0;
    assign mem_resp_err   = mem_resp_valid && resp_err_q;
    assign busy           = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_pt_mem_responder.sv
// Self-checking bench for pt_mem_responder (LATENCY=2, QDEPTH=2, BASE 0).
// Cycle numbers are counted from posedge; inputs change 1ns after a posedge,
// outputs are sampled then or at the following negedge.
module tb_pt_mem_responder;

`ifdef PT_MEM_CLEAR_EN
    localparam int unsigned DepthLog2 = 4;
`else
    localparam int unsigned DepthLog2 = 10;
`endif

    logic        clk;
    logic        rst_n;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mem_resp_err;
    logic        cfg_wr_en;
    logic [31:0] cfg_wr_addr;
    logic [31:0] cfg_wr_data;
    logic        busy;
    logic        req_drop;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } resp_t;

    typedef struct {
        bit          wr;
        logic [31:0] wa;
        logic [31:0] wd;
        logic [31:0] ra;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    resp_t rq[$];
    int    drops[$];
    vec_t  vecs[9];

    pt_mem_responder #(
        .DEPTH_LOG2 (DepthLog2),
        .BASE_ADDR  (32'h0000_0000),
        .LATENCY    (2),
        .QDEPTH     (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_err   (mem_resp_err),
        .cfg_wr_en      (cfg_wr_en),
        .cfg_wr_addr    (cfg_wr_addr),
        .cfg_wr_data    (cfg_wr_data),
        .busy           (busy),
        .req_drop       (req_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Record responses and drops; data/err must be 0 whenever valid is low
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_resp_valid) begin
                rq.push_back('{data: mem_resp_data, err: mem_resp_err, cyc: cyc});
            end else begin
                n_checks++;
                if (mem_resp_data !== 32'd0 || mem_resp_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_outputs cycle %0d: got data 0x%08h err %0b, expected 0",
                             cyc, mem_resp_data, mem_resp_err);
                end
            end
            if (req_drop) drops.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input string name, output resp_t r);
        int n;
        n = 0;
        while (rq.size() == 0 && n < 40) begin
            tick();
            n++;
        end
        if (rq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got no response, expected one within 40 cycles", name);
            r = '{data: 32'hxxxx_xxxx, err: 1'bx, cyc: -1};
        end else begin
            r = rq.pop_front();
        end
    endtask

    task automatic cfg_write(input logic [31:0] a, input logic [31:0] d);
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = a;
        cfg_wr_data = d;
        tick();
        cfg_wr_en   = 1'b0;
    endtask

    initial begin
        resp_t r;
        int    t0;

        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resp_t       r;
        int          t0;
        logic [31:0] exp_seq[3];

        //       wr    wa             wd             ra             exp_d          exp_e
        vecs[0] = '{1'b1, 32'h0000_0004, 32'h0000_1001, 32'h0000_0004, 32'h0000_1001, 1'b0};
        vecs[1] = '{1'b0, 32'h0,         32'h0,         32'h0000_0002, 32'h0,         1'b1};
        vecs[2] = '{1'b0, 32'h0,         32'h0,         32'h0000_1000, 32'h0,         1'b1};
        vecs[3] = '{1'b1, 32'h0000_003C, 32'h8000_00CF, 32'h0000_003C, 32'h8000_00CF, 1'b0};
        vecs[4] = '{1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[5] = '{1'b0, 32'h0,         32'h0,         32'h0000_0003, 32'h0,         1'b1};
        vecs[6] = '{1'b0, 32'h0,         32'h0,         32'hFFFF_FFFC, 32'h0,         1'b1};
        vecs[7] = '{1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0000_0010, 32'h1234_5678, 1'b0};
        // Out-of-range write whose low index bits alias word 0x010: must not land
        vecs[8] = '{1'b1, 32'h0000_1010, 32'hBAD0_BAD0, 32'h0000_0010, 32'h1234_5678, 1'b0};

        rst_n         = 1'b1;
        mem_req_valid = 1'b0;
        mem_req_addr  = 32'd0;
        cfg_wr_en     = 1'b0;
        cfg_wr_addr   = 32'd0;
        cfg_wr_data   = 32'd0;
        #1 rst_n = 1'b0;
        #1;
        check("reset resp_valid", {31'd0, mem_resp_valid}, 32'd0);
        check("reset resp_data", mem_resp_data, 32'd0);
        check("reset resp_err", {31'd0, mem_resp_err}, 32'd0);
        check("reset req_drop", {31'd0, req_drop}, 32'd0);
`ifndef PT_MEM_CLEAR_EN
        check("reset busy", {31'd0, busy}, 32'd0);
`endif
        repeat (3) tick();
        rst_n = 1'b1;

`ifdef PT_MEM_CLEAR_EN
        // 16 clear cycles; cfg write at k=3 is ignored, request at k=5 waits
        t0 = cyc;
        for (int k = 0; k < 16; k++) begin
            if (k == 3) begin
                cfg_wr_en = 1'b1; cfg_wr_addr = 32'h8; cfg_wr_data = 32'h55;
            end
            if (k == 5) begin
                mem_req_valid = 1'b1; mem_req_addr = 32'h8;
            end
            check($sformatf("clear busy k=%0d", k), {31'd0, busy}, 32'd1);
            tick();
            cfg_wr_en     = 1'b0;
            mem_req_valid = 1'b0;
        end
        wait_resp("clear req", r);
        check("clear req cycle", r.cyc, t0 + 19);
        check("clear req data", r.data, 32'd0);
        check("clear req err", {31'd0, r.err}, 32'd0);
        repeat (2) tick();
`else
        tick();
        check("post-reset busy", {31'd0, busy}, 32'd0);
`endif

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].wr) cfg_write(vecs[i].wa, vecs[i].wd);
            mem_req_valid = 1'b1;
            mem_req_addr  = vecs[i].ra;
            t0            = cyc;
            tick();
            mem_req_valid = 1'b0;
            check($sformatf("vec%0d busy pending", i), {31'd0, busy}, 32'd1);
            wait_resp($sformatf("vec%0d", i), r);
            check($sformatf("vec%0d latency", i), r.cyc, t0 + 4);
            check($sformatf("vec%0d data", i), r.data, vecs[i].exp_d);
            check($sformatf("vec%0d err", i), {31'd0, r.err}, {31'd0, vecs[i].exp_e});
            check($sformatf("vec%0d busy done", i), {31'd0, busy}, 32'd0);
            tick();
        end

        // Three back-to-back requests: no drop, responses every 3 cycles
        exp_seq = '{32'h0000_1001, 32'hDEAD_BEEF, 32'h8000_00CF};
        t0 = cyc;
        mem_req_valid = 1'b1; mem_req_addr = 32'h004; tick();
        mem_req_addr  = 32'h000; tick();
        mem_req_addr  = 32'h03C; tick();
        mem_req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_resp($sformatf("b2b%0d", k), r);
            check($sformatf("b2b%0d cycle", k), r.cyc, t0 + 4 + 3 * k);
            check($sformatf("b2b%0d data", k), r.data, exp_seq[k]);
        end
        repeat (3) tick();
        check("b2b drops", drops.size(), 0);

        // Four back-to-back requests: the fourth hits a full FIFO in WAIT
        exp_seq = '{32'h8000_00CF, 32'h0000_1001, 32'hDEAD_BEEF};
        t0 = cyc;
        mem_req_valid = 1'b1; mem_req_addr = 32'h03C; tick();
        mem_req_addr  = 32'h004; tick();
        mem_req_addr  = 32'h000; tick();
        mem_req_addr  = 32'h010; tick();
        mem_req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_resp($sformatf("drop%0d", k), r);
            check($sformatf("drop%0d data", k), r.data, exp_seq[k]);
        end
        repeat (15) tick();
        check("drop extra responses", rq.size(), 0);
        check("drop count", drops.size(), 1);
        if (drops.size() == 1) check("drop cycle", drops[0], t0 + 3);

        // Write in the sampling cycle is not visible
        mem_req_valid = 1'b1; mem_req_addr = 32'h000; t0 = cyc; tick();
        mem_req_valid = 1'b0;
        tick();
        tick();
        cfg_write(32'h000, 32'hFFFF_FFFF);
        wait_resp("same-cycle wr", r);
        check("same-cycle wr cycle", r.cyc, t0 + 4);
        check("same-cycle wr data", r.data, 32'hDEAD_BEEF);
        tick();
        mem_req_valid = 1'b1; mem_req_addr = 32'h000; tick();
        mem_req_valid = 1'b0;
        wait_resp("same-cycle wr landed", r);
        check("same-cycle wr landed data", r.data, 32'hFFFF_FFFF);
        tick();

        // Write one cycle before sampling is visible
        mem_req_valid = 1'b1; mem_req_addr = 32'h004; t0 = cyc; tick();
        mem_req_valid = 1'b0;
        tick();
        cfg_write(32'h004, 32'hFFFF_FFFF);
        wait_resp("early wr", r);
        check("early wr cycle", r.cyc, t0 + 4);
        check("early wr data", r.data, 32'hFFFF_FFFF);
        check("early wr err", {31'd0, r.err}, 32'd0);

        repeat (3) tick();
        check("final no stray responses", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
